horner_ctrl: RTL and testbench
==============================

Name: horner_ctrl

Overview:
- Sequencer for the two-stage multiply/add Horner datapath (multiplier stage feeding an adder stage, one register each).
- Accepts an evaluation request (x, degree), pulls polynomial coefficients highest-order first over a valid/ready stream, and drives the datapath operand ports each step.
- Collects the datapath sum, iterates acc = acc*x + a_k, and returns p(x) mod 2^W with a done pulse.

Parameters:
- W, 32, data width of x, coefficients, datapath operands and result.
- DW, 4, width of degree input; maximum degree 2^DW-1.
- DP_LAT, 2, datapath latency in clocks from operand register update to valid dp_z.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- x_in  in  W  evaluation point, captured on accepted start.
- deg_in  in  DW  polynomial degree n, captured on accepted start.
- busy  out  1  high in every state except IDLE.
- coef_valid  in  1  coefficient source has data.
- coef_data  in  W  coefficient, order a_n, a_(n-1) ... a_0.
- coef_ready  out  1  controller can take a coefficient.
- dp_x1, dp_y1, dp_x2, dp_y2  out  W each  registered datapath operands (product x1*y1, product x2*y2, sum of both).
- dp_z  in  W  datapath sum.
- result  out  W  p(x), held until next accepted start.
- done  out  1  one-cycle pulse when result is valid.

Behaviour:
- Reset (reset low, async): state IDLE; busy, coef_ready, done = 0; result, dp_x1, dp_y1, dp_x2, dp_y2, acc, step counter = 0.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: start=1 captures x_in and deg_in, sets remaining = deg_in, goes to LOAD.
- LOAD: coef_ready=1; on coef_valid, acc <= coef_data. If remaining=0, go to DONE; otherwise go to ISSUE.
- ISSUE: coef_ready=1; on handshake, dp_x1 <= acc, dp_y1 <= x, dp_x2 <= coef_data, dp_y2 <= 1. Then wait_cnt <= 0, remaining decrements, go to WAIT.
- WAIT: coef_ready=0; wait_cnt increments each clock. When wait_cnt == DP_LAT, acc <= dp_z; go to DONE if remaining=0, else back to ISSUE.
- Each step occupies DP_LAT+2 clocks when coef_valid stays high; stalls extend LOAD/ISSUE only.
- DONE: result <= acc and done=1 for exactly one cycle, then IDLE.
- Latency with no stalls: start sampled in cycle 0 gives done in cycle 2 + n*(DP_LAT+2).
- dp_* outputs hold their last values outside ISSUE handshakes.
- Arithmetic: all values unsigned mod 2^W; the datapath discards product high bits; no overflow flag.
- start while busy (including in DONE) is ignored, with no queuing.
- coef_valid while coef_ready=0: the coefficient is not consumed; the source must hold it.
- Reset asserted mid-evaluation aborts immediately to the reset state; partial acc is discarded and done does not fire.

Test Plan:
- Bench datapath: 2-stage registered model, z = x1*y1 + x2*y2 mod 2^32.
- x=4, n=2, coefs 2,3,5 with coef_valid held high -> result=49; start in cycle 0 gives done in cycle 10; coef_ready high in cycles 1, 2 and 6 only.
- n=0, coef 7 -> result=7, done in cycle 2, dp_* unchanged.
- x=0x00010000, n=2, coefs 1,0,0 -> result=0x00000000 (wrap); x=0xFFFFFFFF, n=1, coefs 1,1 -> result=0.
- x=3, n=3, coefs 1,0,0,2 with coef_valid low for 3 cycles before each coefficient -> result=29; every coefficient consumed once; done delayed by exactly 12 cycles versus the unstalled run.
- Second start issued during WAIT -> ignored, result from the first request only. Reset pulsed low in WAIT of step 2 -> all outputs 0 immediately, no done; a fresh request then evaluates correctly.

Source files
------------

// File: rtl/horner_ctrl.sv
// Horner evaluation sequencer. Streams coefficients highest-order first,
// drives the two-product/one-sum datapath with acc*x + a_k each step, and
// captures the datapath sum after DP_LAT clocks. Result is p(x) mod 2^W.
module horner_ctrl #(
   parameter int unsigned W      = 32,
   parameter int unsigned DW     = 4,
   parameter int unsigned DP_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  x_in,
   input  logic [DW-1:0] deg_in,
   output logic          busy,
   input  logic          coef_valid,
   input  logic [W-1:0]  coef_data,
   output logic          coef_ready,
   output logic [W-1:0]  dp_x1,
   output logic [W-1:0]  dp_y1,
   output logic [W-1:0]  dp_x2,
   output logic [W-1:0]  dp_y2,
   input  logic [W-1:0]  dp_z,
   output logic [W-1:0]  result,
   output logic          done
);

   localparam int unsigned CW = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);
   localparam logic [CW-1:0] LAT = CW'(DP_LAT);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   logic [W-1:0]  x_reg;
   logic [W-1:0]  acc;
   logic [DW-1:0] remaining;
   logic [CW-1:0] wait_cnt;

   // Sequencer: state, accumulator, datapath operands and registered handshakes.
   // result/done are loaded on the edge entering DONE so result is already
   // valid during the done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         coef_ready <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         dp_x1      <= '0;
         dp_y1      <= '0;
         dp_x2      <= '0;
         dp_y2      <= '0;
         acc        <= '0;
         x_reg      <= '0;
         remaining  <= '0;
         wait_cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x_reg      <= x_in;
                  remaining  <= deg_in;
                  busy       <= 1'b1;
                  coef_ready <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (coef_valid) begin
                  acc <= coef_data;
                  if (remaining == '0) begin
                     result     <= coef_data;
                     done       <= 1'b1;
                     coef_ready <= 1'b0;
                     state      <= DONE;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (coef_valid) begin
                  dp_x1      <= acc;
                  dp_y1      <= x_reg;
                  dp_x2      <= coef_data;
                  dp_y2      <= W'(1);
                  wait_cnt   <= '0;
                  remaining  <= remaining - DW'(1);
                  coef_ready <= 1'b0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == LAT) begin
                  acc <= dp_z;
                  if (remaining == '0) begin
                     result <= dp_z;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     coef_ready <= 1'b1;
                     state      <= ISSUE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy       <= 1'b0;
               coef_ready <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_horner_ctrl.sv
// Directed bench for horner_ctrl with a registered two-stage datapath model,
// a coefficient source with programmable stalls and a result scoreboard.
module tb_horner_ctrl;

   localparam int unsigned W      = 32;
   localparam int unsigned DW     = 4;
   localparam int unsigned DP_LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  x_in;
   logic [DW-1:0] deg_in;
   logic          busy;
   logic          coef_valid = 1'b0;
   logic [W-1:0]  coef_data = '0;
   logic          coef_ready;
   logic [W-1:0]  dp_x1, dp_y1, dp_x2, dp_y2;
   logic [W-1:0]  dp_z;
   logic [W-1:0]  result;
   logic          done;

   horner_ctrl #(.W(W), .DW(DW), .DP_LAT(DP_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .x_in       (x_in),
      .deg_in     (deg_in),
      .busy       (busy),
      .coef_valid (coef_valid),
      .coef_data  (coef_data),
      .coef_ready (coef_ready),
      .dp_x1      (dp_x1),
      .dp_y1      (dp_y1),
      .dp_x2      (dp_x2),
      .dp_y2      (dp_y2),
      .dp_z       (dp_z),
      .result     (result),
      .done       (done)
   );

   initial forever #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: product stage then sum stage, both registered.
   logic [W-1:0] p1 = '0, p2 = '0, z = '0;
   always @(posedge clk) begin
      p1 <= dp_x1 * dp_y1;
      p2 <= dp_x2 * dp_y2;
      z  <= p1 + p2;
   end
   assign dp_z = z;

   // Coefficient source configuration (written by main) and state (source only).
   logic [W-1:0] src_arr [4];
   int src_len = 0, src_gap = 0, src_gen = 0;
   int idx = 0, gap_left = 0, consumed = 0, seen_gen = 0;

   // Coefficient source: holds data until consumed; after each coefficient,
   // keeps valid low for src_gap cycles during which the controller is ready.
   initial begin
      logic hs, tick;
      forever begin
         @(negedge clk);
         hs   = coef_valid && coef_ready;
         tick = !coef_valid && coef_ready && (gap_left > 0);
         @(posedge clk);
         #1;
         if (src_gen != seen_gen) begin
            seen_gen = src_gen;
            idx      = 0;
            consumed = 0;
            gap_left = src_gap;
         end else if (hs) begin
            idx      = idx + 1;
            consumed = consumed + 1;
            gap_left = src_gap;
         end else if (tick) begin
            gap_left = gap_left - 1;
         end
         coef_valid = (idx < src_len) && (gap_left == 0);
         coef_data  = (idx < src_len) ? src_arr[idx] : '0;
      end
   end

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q [$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic no_done(input int cycles, input string tag);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check(tag, W'(seen), '0);
   endtask

   // inj_kind: 0 none, 1 extra start pulse in cycle inj_cyc, 2 reset in cycle inj_cyc
   task automatic run_eval(input string tag, input logic [W-1:0] x, input int n,
                           input logic [W-1:0] c0, input logic [W-1:0] c1,
                           input logic [W-1:0] c2, input logic [W-1:0] c3,
                           input int gap, input logic [W-1:0] expv, input int exp_lat,
                           input int inj_kind, input int inj_cyc,
                           output logic [31:0] mask);
      int unsigned c0cyc;
      int rel, lat;
      logic got, aborted;
      logic [W-1:0] expr;
      @(posedge clk);
      #2;
      src_arr[0] = c0;
      src_arr[1] = c1;
      src_arr[2] = c2;
      src_arr[3] = c3;
      src_len    = n + 1;
      src_gap    = gap;
      src_gen    = src_gen + 1;
      @(posedge clk);
      #1;
      x_in   = x;
      deg_in = DW'(n);
      start  = 1'b1;
      c0cyc  = cyc;
      if (inj_kind != 2) exp_q.push_back(expv);
      mask    = '0;
      got     = 1'b0;
      aborted = 1'b0;
      lat     = -1;
      for (int k = 0; k < 200 && !got && !aborted; k++) begin
         @(negedge clk);
         rel = int'(cyc - c0cyc);
         if (rel < 32) mask[rel] = coef_ready;
         if (done) begin
            got = 1'b1;
            lat = rel;
         end else begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (inj_kind == 1 && rel + 1 == inj_cyc) begin
               start  = 1'b1;
               x_in   = 32'd9;
               deg_in = DW'(3);
            end
            if (inj_kind == 2 && rel + 1 == inj_cyc) begin
               reset = 1'b0;
               #1;
               check({tag, " rst busy"}, W'(busy), '0);
               check({tag, " rst coef_ready"}, W'(coef_ready), '0);
               check({tag, " rst done"}, W'(done), '0);
               check({tag, " rst result"}, result, '0);
               check({tag, " rst dp_x1"}, dp_x1, '0);
               check({tag, " rst dp_y1"}, dp_y1, '0);
               check({tag, " rst dp_x2"}, dp_x2, '0);
               check({tag, " rst dp_y2"}, dp_y2, '0);
               repeat (2) @(posedge clk);
               #1;
               reset   = 1'b1;
               aborted = 1'b1;
            end
         end
      end
      start = 1'b0;
      if (inj_kind != 2) begin
         check({tag, " done seen"}, W'(got), W'(1));
         if (got) begin
            expr = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check({tag, " result"}, result, expr);
            if (exp_lat >= 0) check({tag, " latency"}, W'(lat), W'(exp_lat));
            check({tag, " coefs consumed"}, W'(consumed), W'(n + 1));
            @(negedge clk);
            check({tag, " done one cycle"}, W'(done), '0);
            check({tag, " idle after done"}, W'(busy), '0);
         end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
      end
   endtask

   initial begin
      logic [31:0] mask;
      reset  = 1'b0;
      start  = 1'b0;
      x_in   = '0;
      deg_in = '0;
      repeat (2) @(negedge clk);
      check("reset busy", W'(busy), '0);
      check("reset coef_ready", W'(coef_ready), '0);
      check("reset done", W'(done), '0);
      check("reset result", result, '0);
      check("reset dp_y2", dp_y2, '0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      run_eval("basic", 32'd4, 2, 32'd2, 32'd3, 32'd5, 32'd0, 0, 32'd49, 10, 0, 0, mask);
      check("basic ready cycles", mask, 32'h46);

      run_eval("deg0", 32'd8, 0, 32'd7, 32'd0, 32'd0, 32'd0, 0, 32'd7, 2, 0, 0, mask);
      check("deg0 dp_x1 held", dp_x1, 32'd11);
      check("deg0 dp_y1 held", dp_y1, 32'd4);
      check("deg0 dp_x2 held", dp_x2, 32'd5);
      check("deg0 dp_y2 held", dp_y2, 32'd1);

      run_eval("wrap sq", 32'h0001_0000, 2, 32'd1, 32'd0, 32'd0, 32'd0, 0, 32'd0, 10, 0, 0, mask);
      run_eval("wrap max", 32'hFFFF_FFFF, 1, 32'd1, 32'd1, 32'd0, 32'd0, 0, 32'd0, 6, 0, 0, mask);

      run_eval("deg3", 32'd3, 3, 32'd1, 32'd0, 32'd0, 32'd2, 0, 32'd29, 14, 0, 0, mask);
      run_eval("stall", 32'd3, 3, 32'd1, 32'd0, 32'd0, 32'd2, 3, 32'd29, 14 + 12, 0, 0, mask);

      run_eval("busy start", 32'd2, 1, 32'd1, 32'd1, 32'd0, 32'd0, 0, 32'd3, 6, 1, 3, mask);
      no_done(20, "busy start extra done");

      run_eval("abort", 32'd4, 2, 32'd2, 32'd3, 32'd5, 32'd0, 0, 32'd0, -1, 2, 7, mask);
      no_done(15, "abort no done");

      run_eval("after abort", 32'd5, 2, 32'd1, 32'd2, 32'd3, 32'd0, 0, 32'd38, 10, 0, 0, mask);

      check("scoreboard empty", W'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
